// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: redirect input, instruction memory request/response, and decoder handoff.
// The fetch stage connects through the master modport; the environment or core uses the slave modport.
interface instruction_fetch_if #(
    parameter int XLEN = 64
);
    // A valid/ready pair transfers exactly on a rising edge where both are high. The producer
    // holds its payload stable while valid is high. The consumer may raise ready at any time.
    // mem_resp_valid has no ready: exactly one response returns per accepted request, in order.
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req_valid;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_ready;
    logic            mem_resp_valid;
    logic [31:0]     mem_resp_data;
    logic [31:0]     ir;
    logic [XLEN-1:0] ir_pc;
    logic            ir_valid;
    logic            ir_ready;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, ir_ready,
        output mem_req_valid, mem_req_addr, ir, ir_pc, ir_valid
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, ir_ready,
        input  mem_req_valid, mem_req_addr, ir, ir_pc, ir_valid
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding word read at a time, and a small {pc, word} FIFO feeding decode.
// Optional FETCH_MISALIGN_CHECK_EN adds the fetch_misaligned flag and stalls on misaligned redirects.
module instruction_fetch #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        bus,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic                       fetch_misaligned,
`endif
    output logic [1:0]                 fetch_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [XLEN-1:0]  pc, req_pc, load_pc;
    logic [XLEN-1:0]  fifo_pc   [FIFO_DEPTH];
    logic [31:0]      fifo_word [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             run;
    logic             halt;
    logic             req_valid, req_fire, push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            misaligned_q <= |bus.redirect_pc[1:0];
        end
    end

    assign halt             = misaligned_q;
    assign load_pc          = bus.redirect_pc;
    assign fetch_misaligned = misaligned_q;
`else
    assign halt    = 1'b0;
    assign load_pc = bus.redirect_pc & ~XLEN'(3);
`endif

    // run keeps requests off during reset and for the cycle in which reset is sampled low.
    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        case (state)
            ST_REQ: begin
                req_valid = run && !halt && !bus.redirect_valid && (count < CNT_W'(FIFO_DEPTH));
                if (req_valid && bus.mem_req_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid)      state_next = ST_REQ;
                else if (bus.redirect_valid) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.mem_resp_valid) state_next = ST_REQ;
            end
            default: state_next = ST_REQ;
        endcase
    end

    assign req_fire = req_valid && bus.mem_req_ready;
    assign push     = (state == ST_WAIT) && bus.mem_resp_valid && !bus.redirect_valid;
    assign pop      = bus.ir_valid && bus.ir_ready && !bus.redirect_valid;

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = pc;
    assign bus.ir_valid      = (count != '0);
    assign bus.ir            = bus.ir_valid ? fifo_word[rd_ptr] : NOP;
    assign bus.ir_pc         = bus.ir_valid ? fifo_pc[rd_ptr]   : '0;
    assign fetch_state       = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_REQ;
            pc     <= RESET_PC;
            req_pc <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            run    <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
            if (bus.redirect_valid) begin
                pc     <= load_pc;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (req_fire) begin
                    req_pc <= pc;
                    pc     <= pc + XLEN'(4);
                end
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage needs no reset; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_word[wr_ptr] <= bus.mem_resp_data;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model, directed scenarios, randomized traffic,
// and a scoreboard that checks the program-order instruction stream.
module tb_instruction_fetch;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] fetch_state;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic       fetch_misaligned;
`endif

    instruction_fetch_if #(.XLEN(64)) bus ();

    instruction_fetch #(
        .XLEN(64), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_misaligned (fetch_misaligned),
`endif
        .fetch_state      (fetch_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scoreboard queues: program-order pcs the decoder must see, and addresses memory must be asked for
    logic [63:0] exp_q[$];
    logic [63:0] req_q[$];

    // memory model state
    logic [63:0] pend_addr[$];
    int          pend_wait[$];
    int          resp_delay = 0;
    bit          rand_delay = 0;
    bit          rand_ready = 0;
    bit          last_fire;
    int          req_count = 0;
    int          pop_count = 0;
    bit          prev_redir = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (bound expired) at %0t", name, $time);
    endtask

    // After reset or a redirect to base, fetch proceeds strictly sequentially from base.
    task automatic model_base(input logic [63:0] base);
        exp_q.delete();
        req_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(base + 64'(4 * i));
            req_q.push_back(base + 64'(4 * i));
        end
    endtask

    function automatic bit resp_due();
        return (pend_addr.size() > 0) && (pend_wait[0] == 0);
    endfunction

    // driver: one clock cycle of inputs plus the memory model
    task automatic step(input bit rdy, input bit redir, input logic [63:0] target);
        logic [63:0] a;
        @(negedge clk);
        if (resp_due()) begin
            a = pend_addr.pop_front();
            void'(pend_wait.pop_front());
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = a[31:0] ^ KEY;
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = $urandom;
            if (pend_wait.size() > 0) pend_wait[0] = pend_wait[0] - 1;
        end
        bus.ir_ready       = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = target;
        bus.mem_req_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (redir) model_base(target);
        #1;
        last_fire = bus.mem_req_valid && bus.mem_req_ready;
        if (last_fire) begin
            pend_addr.push_back(bus.mem_req_addr);
            pend_wait.push_back(rand_delay ? int'($urandom_range(0, 2)) : resp_delay);
            req_count++;
        end
        if (bus.ir_valid && bus.ir_ready && !redir) pop_count++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.ir_ready       = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        pend_addr.delete();
        pend_wait.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst_ir_valid", 64'(bus.ir_valid), 64'd0);
        check("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
        check("rst_ir", 64'(bus.ir), 64'(NOP));
        check("rst_ir_pc", bus.ir_pc, 64'd0);
        check("rst_state", 64'(fetch_state), 64'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misaligned", 64'(fetch_misaligned), 64'd0);
`endif
        model_base(RESET_PC);
        reset = 1'b0;
        #1;
        check("req_valid_at_release", 64'(bus.mem_req_valid), 64'd0);
    endtask

    // monitor: compares everything the DUT presents against the scoreboard
    always @(negedge clk) begin
        logic [63:0] e;
        #2;
        if (reset) begin
            prev_redir = 1'b0;
        end else begin
            if (bus.redirect_valid) check("req_during_redirect", 64'(bus.mem_req_valid), 64'd0);
            if (prev_redir) check("ir_valid_after_redirect", 64'(bus.ir_valid), 64'd0);
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (req_q.size() == 0) fail_now("req_q_empty");
                else begin
                    e = req_q.pop_front();
                    check("req_addr", bus.mem_req_addr, e);
                end
            end
            if (bus.ir_valid && bus.ir_ready && !bus.redirect_valid) begin
                if (exp_q.size() == 0) fail_now("exp_q_empty");
                else begin
                    e = exp_q.pop_front();
                    check("ir_pc", bus.ir_pc, e);
                    check("ir_word", 64'(bus.ir), 64'(e[31:0] ^ KEY));
                end
            end
            if (!bus.ir_valid) begin
                check("idle_ir", 64'(bus.ir), 64'(NOP));
                check("idle_ir_pc", bus.ir_pc, 64'd0);
            end
            prev_redir = bus.redirect_valid;
        end
    end

    initial begin
        int n;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.ir_ready       = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_req_ready  = 1'b1;

        // streaming with single-cycle memory: one instruction every 2 cycles
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        pop_count = 0;
        req_count = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0);
        check("throughput_pops", 64'(pop_count), 64'd10);
        check("throughput_reqs", 64'(req_count), 64'd10);

        // decoder stalled: FIFO fills with two entries, then requests stop
        do_reset();
        req_count = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check("stall_req_count", 64'(req_count), 64'd2);
        check("stall_req_valid", 64'(bus.mem_req_valid), 64'd0);
        pop_count = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
        check("stall_resume_pops", 64'(pop_count >= 4), 64'd1);

        // redirect while waiting on a slow response
        resp_delay = 3;
        n = 0;
        do begin step(1'b1, 1'b0, '0); n++; end while (!last_fire && n < 20);
        if (!last_fire) fail_now("wait_for_request");
        step(1'b1, 1'b1, 64'h100);
        pop_count = 0;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0);
        check("redirect_wait_pops", 64'(pop_count >= 4), 64'd1);

        // redirect coinciding with a response and a pop
        resp_delay = 1;
        n = 0;
        while (!(resp_due() && bus.ir_valid) && n < 30) begin step(1'b0, 1'b0, '0); n++; end
        if (!(resp_due() && bus.ir_valid)) fail_now("wait_for_resp_and_entry");
        step(1'b1, 1'b1, 64'h200);
        step(1'b1, 1'b0, '0);
        check("fifo_empty_after_redirect", 64'(bus.ir_valid), 64'd0);
        pop_count = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0);
        check("redirect_resp_pops", 64'(pop_count >= 4), 64'd1);

        // pc wraps modulo 2^64
        resp_delay = 0;
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        pop_count = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        check("wrap_pops", 64'(pop_count >= 3), 64'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
        step(1'b1, 1'b1, 64'h102);
        req_count = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        check("misaligned_flag", 64'(fetch_misaligned), 64'd1);
        check("misaligned_no_req", 64'(req_count), 64'd0);
        step(1'b1, 1'b1, 64'h104);
        step(1'b1, 1'b0, '0);
        check("misaligned_cleared", 64'(fetch_misaligned), 64'd0);
        pop_count = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
        check("realigned_pops", 64'(pop_count >= 3), 64'd1);
`endif

        // randomized traffic, including a reset in the middle
        rand_delay = 1;
        rand_ready = 1;
        pop_count  = 0;
        for (int i = 0; i < 600; i++) begin
            logic [63:0] tgt;
            if (i == 300) do_reset();
            tgt = {54'($urandom_range(0, 3) == 0 ? $urandom : 0), 8'($urandom), 2'b00};
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0), tgt);
        end
        check("random_progress", 64'(pop_count >= 50), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the RV64I/M core. It holds the program counter, issues one word-aligned read at a time to the instruction memory port, and buffers returned words with their PC in a small FIFO. It presents the oldest word to the decoder over a valid/ready handshake on `ir`. A redirect from execute (branch, jump, trap) flushes the buffer and discards any in-flight response.

## Interface
- `XLEN`, 64, PC and address width.
- `RESET_PC`, 64'h0, PC loaded on reset.
- `FIFO_DEPTH`, 2, buffered instruction entries; power of two, at least 2.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_pc` in XLEN: target PC.
- `mem_req_valid` out 1: read request valid.
- `mem_req_addr` out XLEN: read address, always 4-byte aligned.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_resp_valid` in 1: read data valid; one response per accepted request, in order.
- `mem_resp_data` in 32: instruction word.
- `ir` out 32: instruction to the decoder.
- `ir_pc` out XLEN: PC of `ir`.
- `ir_valid` out 1: `ir`/`ir_pc` valid.
- `ir_ready` in 1: decoder consumes the head entry.

## Operation
- State: `pc` register, FIFO of {pc, word}, `count`, FSM in {REQ, WAIT, DRAIN}; at most one outstanding request.
- **REQ**
  - `mem_req_valid` = 1 when `count` < `FIFO_DEPTH`; `mem_req_addr` = `pc`.
  - On `mem_req_valid` & `mem_req_ready`: the request's PC is latched as `req_pc`, `pc` += 4 (wraps modulo 2^XLEN), go to WAIT.
- **WAIT**
  - On `mem_resp_valid`: push {`req_pc`, `mem_resp_data`}, go to REQ.
  - Space is guaranteed because a request is only issued when `count` < `FIFO_DEPTH`.
- **DRAIN**
  - On `mem_resp_valid`: drop the data, go to REQ.
  - `mem_req_valid` = 0.
- **Pop**: on `ir_valid` & `ir_ready`. Push and pop in the same cycle leave `count` unchanged.
- **Redirect** has priority over every other event in its cycle:
  - FIFO cleared (`count` = 0, pointers reset); any pop that cycle is ignored.
  - `pc` loaded from `redirect_pc`.
  - No request is issued that cycle (`mem_req_valid` = 0).
  - Next state: DRAIN if in WAIT and `mem_resp_valid` = 0; REQ if in WAIT with `mem_resp_valid` = 1 (that response is dropped, not pushed); DRAIN stays DRAIN unless its response arrives; otherwise REQ.
- `mem_resp_valid` in REQ is a protocol error and is ignored.
- When `ir_valid` = 0: `ir` = 32'h0000_0013 (nop) and `ir_pc` = 0.

## Timing
- Reset values: `pc` = `RESET_PC`, `count` = 0, state REQ, `ir_valid` = 0, `mem_req_valid` = 0, `ir` = 32'h0000_0013, `ir_pc` = 0.
- `mem_req_valid` first rises in the cycle after `reset` deasserts.
- **Reset mid-operation**: an outstanding response arriving during or after reset is ignored. State returns to REQ; the memory must drop its pending response on `reset`.
- **Latency**:
  - Response accepted at edge N gives `ir_valid` = 1 from cycle N+1.
  - Minimum request-to-`ir_valid` is 2 cycles (request accepted at edge N, response at edge N+1, `ir_valid` from N+2).
  - Sustained throughput is one instruction per 2 cycles with single-cycle memory.
- `ir`, `ir_pc`, `ir_valid` are driven from registers (FIFO head) with no combinational path from `ir_ready`. `mem_req_valid` depends combinationally only on `redirect_valid`.
- **Redirect**: asserted at edge N gives `ir_valid` = 0 in cycle N+1. A new request to `redirect_pc` is issued in cycle N+1 if state is REQ, otherwise after the drained response.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - Adds output `fetch_misaligned` (1 bit, reset 0).
  - A redirect with `redirect_pc[1:0]` != 0 sets `fetch_misaligned`, loads `pc`, and issues no requests until an aligned redirect or `reset`. An aligned redirect clears the flag.
- Undefined: no port; `redirect_pc[1:0]` is forced to 0 when loaded.

## Test plan
- Reset, then memory always ready with 1-cycle responses returning word = addr ^ 32'hA5A5_0000; `ir_ready` = 1 -> `ir_pc` sequence 0, 4, 8, 12, each `ir` matching, one entry every 2 cycles.
- `ir_ready` = 0 for 10 cycles -> exactly 2 requests issued (0x0, 0x4), `mem_req_valid` = 0 afterwards. `ir_ready` = 1 -> entries 0x0 then 0x4, then fetching resumes at 0x8.
- Redirect to 0x100 in WAIT with the response delayed 3 cycles -> the late response is dropped, the next request addr is 0x100, the first `ir_pc` is 0x100.
- Redirect to 0x200 in the same cycle as `mem_resp_valid` and `ir_ready` -> FIFO empty next cycle, the response is not pushed, the next request is to 0x200.
- `RESET_PC` = 64'hFFFF_FFFF_FFFF_FFFC -> `mem_req_addr` sequence FFFF_FFFF_FFFF_FFFC then 0x0.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 0x102 -> `fetch_misaligned` = 1 and no requests; a later redirect to 0x104 -> flag cleared, request to 0x104.
